// File: rtl/bunny_pkg.sv
// bunny_pkg -- shared types and constants for the bunny jump controller.
//   jump_state_t : encoded FSM state (GROUND/AIR/COOLDOWN, 2'd3 illegal)
//   ROW_TOP/ROW_BOTTOM : LCD character row codes
//   JCNT_W : width of the saturating jump counter
package bunny_pkg;

    typedef enum logic [1:0] {
        ST_GROUND  = 2'd0,
        ST_AIR     = 2'd1,
        ST_COOL    = 2'd2,
        ST_ILLEGAL = 2'd3
    } jump_state_t;

    localparam logic ROW_TOP    = 1'b0;
    localparam logic ROW_BOTTOM = 1'b1;

    localparam int JCNT_W = 8;

    // Increment that sticks at all-ones.
    function automatic logic [JCNT_W-1:0] sat_inc(input logic [JCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bunny_jump_ctrl_if.sv
// bunny_jump_ctrl_if -- game-side bundle of the bunny jump controller.
//   run, btn_jump       : game enable and raw jump button (into the controller)
//   zero_top_one_bottom : registered LCD row (0 = top/airborne, 1 = bottom)
//   busy, jump_state    : FSM status
//   jump_cnt            : saturating count of jumps taken
//   tick                : one-cycle game-tick strobe
// modport master drives the inputs (game/testbench), slave is the controller.
interface bunny_jump_ctrl_if;
    import bunny_pkg::*;

    logic              run;
    logic              btn_jump;
    logic              zero_top_one_bottom;
    logic              busy;
    logic [1:0]        jump_state;
    logic [JCNT_W-1:0] jump_cnt;
    logic              tick;

    modport master (
        output run, btn_jump,
        input  zero_top_one_bottom, busy, jump_state, jump_cnt, tick
    );

    modport slave (
        input  run, btn_jump,
        output zero_top_one_bottom, busy, jump_state, jump_cnt, tick
    );

endinterface

// File: rtl/bunny_jump_ctrl_btn_debounce.sv
// btn_debounce -- 2-flop synchronizer plus level debouncer for a raw button.
//   clk, reset : clock, asynchronous active-low reset
//   raw        : asynchronous button input, active-high
//   level      : debounced level
//   rise       : one-cycle pulse, high in the first cycle level reads 1
// The level flips only after the synchronized input has disagreed with it
// for DEBOUNCE_CYC consecutive cycles; any agreement restarts the count.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 20000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int            CW   = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 != level) begin
                if (cnt == LAST) begin
                    level <= sync2;
                    rise  <= sync2;   // registered with level, so rise and level align
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/bunny_jump_ctrl.sv
// bunny_jump_ctrl -- jump FSM for the LCD bunny game.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : bunny_jump_ctrl_if.slave (run, btn_jump in; row, busy,
//                jump_state, jump_cnt, tick out)
// A press on the debounced jump button launches the bunny to the top row for
// AIR_TICKS game ticks, then a COOL_TICKS landing lockout follows.
// Optional feature: define BUNNY_JUMP_BUFFER_EN to remember a press made during
// the lockout and relaunch straight out of COOLDOWN.
module bunny_jump_ctrl
    import bunny_pkg::*;
#(
    parameter int TICK_DIV     = 250000,
    parameter int DEBOUNCE_CYC = 20000,
    parameter int AIR_TICKS    = 8,
    parameter int COOL_TICKS   = 4
) (
    input  logic               clk,
    input  logic               reset,
    bunny_jump_ctrl_if.slave   bus
);

    localparam int            TW     = $clog2(TICK_DIV);
    localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);

    localparam int            CMAX   = (AIR_TICKS > COOL_TICKS) ? AIR_TICKS : COOL_TICKS;
    localparam int            CW     = (CMAX < 2) ? 1 : $clog2(CMAX + 1);
    localparam logic [CW-1:0] AIR_LD = CW'(AIR_TICKS);
    localparam logic [CW-1:0] CL_LD  = CW'(COOL_TICKS);
    localparam logic [CW-1:0] ONE    = CW'(1);

    // ---------------- button front end ----------------
    logic btn_level;
    logic press_pulse;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.btn_jump),
        .level (btn_level),
        .rise  (press_pulse)
    );

    // ---------------- game tick ----------------
    logic [TW-1:0] tcnt;
    logic          tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)               tcnt <= '0;
        else if (tcnt == T_LAST)  tcnt <= '0;
        else                      tcnt <= tcnt + 1'b1;
    end

    assign tick = (tcnt == T_LAST);

    // ---------------- FSM ----------------
    jump_state_t       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              row_q, row_d;
    logic [JCNT_W-1:0] jcnt_q, jcnt_d;
`ifdef BUNNY_JUMP_BUFFER_EN
    logic              buf_q, buf_d;
`endif

    // State register; the row, tick counters and jump count ride along so the
    // row output is a flop and changes on the same edge as the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_GROUND;
            cnt_q   <= '0;
            row_q   <= ROW_BOTTOM;
            jcnt_q  <= '0;
`ifdef BUNNY_JUMP_BUFFER_EN
            buf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            jcnt_q  <= jcnt_d;
`ifdef BUNNY_JUMP_BUFFER_EN
            buf_q   <= buf_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        jcnt_d  = jcnt_q;
`ifdef BUNNY_JUMP_BUFFER_EN
        buf_d   = buf_q;
`endif
        if (!bus.run) begin
            // Game stopped: park on the ground, keep the jump tally.
            state_d = ST_GROUND;
            cnt_d   = '0;
            row_d   = ROW_BOTTOM;
`ifdef BUNNY_JUMP_BUFFER_EN
            buf_d   = 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_GROUND: begin
                    row_d = ROW_BOTTOM;
                    if (press_pulse) begin
                        state_d = ST_AIR;
                        cnt_d   = AIR_LD;
                        row_d   = ROW_TOP;
                        jcnt_d  = sat_inc(jcnt_q);
                    end
                end
                ST_AIR: begin
                    if (tick) begin
                        // <= covers a zero load as "last tick" instead of wrapping
                        if (cnt_q <= ONE) begin
                            state_d = ST_COOL;
                            cnt_d   = CL_LD;
                            row_d   = ROW_BOTTOM;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                ST_COOL: begin
`ifdef BUNNY_JUMP_BUFFER_EN
                    if (press_pulse) buf_d = 1'b1;
`endif
                    if (tick) begin
                        if (cnt_q <= ONE) begin
`ifdef BUNNY_JUMP_BUFFER_EN
                            // A press on the final tick counts as buffered too.
                            if (buf_q || press_pulse) begin
                                state_d = ST_AIR;
                                cnt_d   = AIR_LD;
                                row_d   = ROW_TOP;
                                jcnt_d  = sat_inc(jcnt_q);
                                buf_d   = 1'b0;
                            end else begin
                                state_d = ST_GROUND;
                                cnt_d   = '0;
                            end
`else
                            state_d = ST_GROUND;
                            cnt_d   = '0;
`endif
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_GROUND;
                    cnt_d   = '0;
                    row_d   = ROW_BOTTOM;
`ifdef BUNNY_JUMP_BUFFER_EN
                    buf_d   = 1'b0;
`endif
                end
            endcase
        end
    end

    // Output logic.
    logic       busy;
    logic [1:0] jstate;

    always_comb begin
        busy   = (state_q != ST_GROUND);
        jstate = state_q;
    end

    assign bus.zero_top_one_bottom = row_q;
    assign bus.busy                = busy;
    assign bus.jump_state          = jstate;
    assign bus.jump_cnt            = jcnt_q;
    assign bus.tick                = tick;

    // The debounced level itself is only consumed through its rise pulse here.
    logic unused_ok;
    assign unused_ok = btn_level;

endmodule

// File: tb/tb_bunny_jump_ctrl.sv
// tb_bunny_jump_ctrl -- directed self-checking bench for bunny_jump_ctrl
// (TICK_DIV=4, DEBOUNCE_CYC=3, AIR_TICKS=5, COOL_TICKS=2).
module tb_bunny_jump_ctrl;

    logic clk = 1'b0;
    logic reset;

    bunny_jump_ctrl_if bus ();

    bunny_jump_ctrl #(
        .TICK_DIV     (4),
        .DEBOUNCE_CYC (3),
        .AIR_TICKS    (5),
        .COOL_TICKS   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Advance n clock edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int lim, input string tag);
        int k;
        k = 0;
        while (bus.jump_state !== s && k < lim) begin
            step(1);
            k++;
        end
        chk(tag, bus.jump_state, s);
    endtask

    // Hold the button for 5 cycles: the rise pulse is visible on return and
    // the FSM reacts on the next edge.
    task automatic press();
        bus.btn_jump = 1'b1;
        step(5);
        bus.btn_jump = 1'b0;
    endtask

    logic [7:0] tick_obs;
    int idle_bad, air_len, air_tk, cool_tk, row_bad, seen, done;
    int busy_seen, reentry, at_gnd, tk, air_miss;
    logic [7:0] jc0, jc1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.run      = 1'b1;
        bus.btn_jump = 1'b0;
        reset        = 1'b0;
        step(3);

        // ---- reset state ----
        chk("rst_row",   bus.zero_top_one_bottom, 1);
        chk("rst_state", bus.jump_state, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_jcnt",  bus.jump_cnt, 0);
        chk("rst_tick",  bus.tick, 0);

        // ---- idle after release: tick every 4th cycle ----
        reset    = 1'b1;
        tick_obs = '0;
        idle_bad = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            tick_obs[i] = bus.tick;
            if (bus.zero_top_one_bottom !== 1'b1 || bus.jump_state !== 2'd0) idle_bad++;
        end
        chk("tick_pattern", tick_obs, 8'b0100_0100);
        chk("idle_ground",  idle_bad, 0);

        // ---- single jump, button held 10 cycles ----
        air_len = 0; air_tk = 0; cool_tk = 0; row_bad = 0; seen = 0; done = 0;
        bus.btn_jump = 1'b1;
        for (int c = 0; c < 200 && done == 0; c++) begin
            if (c == 10) bus.btn_jump = 1'b0;
            step(1);
            if ((bus.jump_state === 2'd1) != (bus.zero_top_one_bottom === 1'b0)) row_bad++;
            if (bus.jump_state === 2'd1) begin
                air_len++;
                seen = 1;
                if (bus.tick) air_tk++;
            end else if (bus.jump_state === 2'd2) begin
                if (bus.tick) cool_tk++;
            end else if (seen != 0) begin
                done = 1;
            end
        end
        chk("j1_done",       done, 1);
        chk("j1_air_ticks",  air_tk, 5);
        chk("j1_cool_ticks", cool_tk, 2);
        chk("j1_air_len_17_20", (air_len >= 17 && air_len <= 20) ? 1 : 0, 1);
        chk("j1_row_in_air", row_bad, 0);
        chk("j1_jcnt",       bus.jump_cnt, 1);

        // ---- bouncing button: no jump ----
        busy_seen = 0;
        for (int c = 0; c < 20; c++) begin
            bus.btn_jump = ((c / 2) % 2 == 0);
            step(1);
            if (bus.busy) busy_seen = 1;
        end
        bus.btn_jump = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step(1);
            if (bus.busy) busy_seen = 1;
        end
        chk("bounce_no_jump", busy_seen, 0);
        chk("bounce_jcnt",    bus.jump_cnt, 1);

        // ---- press in AIR, then press in COOLDOWN ----
        jc0 = bus.jump_cnt;
        press();
        wait_state(2'd1, 10, "p1_air");
        step(5);
        press();
        step(1);
        chk("p2_still_air", bus.jump_state, 1);
        chk("p2_ignored",   bus.jump_cnt, 32'(jc0) + 1);
        wait_state(2'd2, 40, "p1_cool");
        press();
        reentry = 0; at_gnd = 0;
        for (int c = 0; c < 80 && at_gnd == 0; c++) begin
            step(1);
            if (bus.jump_state === 2'd1) reentry = 1;
            if (bus.jump_state === 2'd0) at_gnd = 1;
        end
        chk("p3_back_ground", at_gnd, 1);
`ifdef BUNNY_JUMP_BUFFER_EN
        chk("p3_buffered_jump", reentry, 1);
        chk("p3_jcnt",          bus.jump_cnt, 32'(jc0) + 2);
`else
        chk("p3_no_jump", reentry, 0);
        chk("p3_jcnt",    bus.jump_cnt, 32'(jc0) + 1);
`endif
        step(10);

        // ---- drop run at the second AIR tick ----
        press();
        wait_state(2'd1, 10, "r_air");
        jc1 = bus.jump_cnt;
        tk  = 0;
        for (int c = 0; c < 40 && tk < 2; c++) begin
            step(1);
            if (bus.tick) tk++;
        end
        chk("r_row_top", bus.zero_top_one_bottom, 0);
        bus.run = 1'b0;
        step(1);
        chk("r_row_bottom", bus.zero_top_one_bottom, 1);
        chk("r_state",      bus.jump_state, 0);
        chk("r_busy",       bus.busy, 0);
        chk("r_jcnt_hold",  bus.jump_cnt, 32'(jc1));
        bus.run = 1'b1;
        step(10);
        chk("r_stays_ground", bus.jump_state, 0);

        // ---- reset at the second AIR tick ----
        press();
        wait_state(2'd1, 10, "x_air");
        tk = 0;
        for (int c = 0; c < 40 && tk < 2; c++) begin
            step(1);
            if (bus.tick) tk++;
        end
        reset = 1'b0;
        #1;
        chk("x_row_now",  bus.zero_top_one_bottom, 1);
        chk("x_state",    bus.jump_state, 0);
        chk("x_jcnt_clr", bus.jump_cnt, 0);
        step(2);
        reset = 1'b1;
        step(30);
        chk("x_no_complete", bus.jump_state, 0);
        chk("x_row_bottom",  bus.zero_top_one_bottom, 1);

        // ---- saturation: 260 jumps, each cut short with run ----
        air_miss = 0;
        for (int j = 0; j < 260; j++) begin
            press();
            step(1);
            if (bus.jump_state !== 2'd1) air_miss++;
            bus.run = 1'b0;
            step(1);
            bus.run = 1'b1;
            step(5);
            if (j == 253) chk("sat_254", bus.jump_cnt, 254);
            if (j == 254) chk("sat_255", bus.jump_cnt, 255);
        end
        chk("sat_air_entries", air_miss, 0);
        chk("sat_hold_255",    bus.jump_cnt, 255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
